// File: rtl/uart_pkg.sv
// Shared types and constants for the UART-to-register-bus bridge.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    WRITE,
    READ,
    RWAIT,
    RESP
  } state_e;

  localparam logic [7:0] CMD_WR      = 8'h57;
  localparam logic [7:0] CMD_RD      = 8'h52;
  localparam logic [7:0] ACK_DEFAULT = 8'h06;
  localparam logic [7:0] NAK_DEFAULT = 8'h15;

endpackage

// File: rtl/uart_resp_ser.sv
// Serialises a 1- or 4-byte response, MSB first, onto a valid/ready byte handshake.
module uart_resp_ser (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        word,
  input  logic [31:0] data,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        done_c
);

  logic        tx_valid_q, tx_valid_d;
  logic [31:0] shift_q, shift_d;
  logic [1:0]  left_q, left_d;

  // left_q counts bytes remaining after the one currently offered
  always_comb begin
    tx_valid_d = tx_valid_q;
    shift_d    = shift_q;
    left_d     = left_q;
    done_c     = 1'b0;
    if (load) begin
      tx_valid_d = 1'b1;
      shift_d    = data;
      left_d     = word ? 2'd3 : 2'd0;
    end else if (tx_valid_q && tx_ready) begin
      if (left_q == 2'd0) begin
        tx_valid_d = 1'b0;
        done_c     = 1'b1;
      end else begin
        shift_d = {shift_q[23:0], 8'h00};
        left_d  = left_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid_q <= 1'b0;
      shift_q    <= '0;
      left_q     <= '0;
    end else begin
      tx_valid_q <= tx_valid_d;
      shift_q    <= shift_d;
      left_q     <= left_d;
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = shift_q[31:24];

endmodule

// File: rtl/uart_bus_master.sv
// UART command bridge: 'W'/'R' byte frames drive a 12-bit address, 32-bit data register bus.
// Optional inter-byte idle timeout enabled by defining UART_BUS_MASTER_TIMEOUT_EN.
module uart_bus_master
  import uart_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned RD_WAIT_MAX    = 16,
  parameter logic [7:0]  ACK_BYTE       = ACK_DEFAULT,
  parameter logic [7:0]  NAK_BYTE       = NAK_DEFAULT
) (
  input  logic        clk,
  input  logic        rstB,
  input  logic        rxValid,
  input  logic [7:0]  rxData,
  output logic        txValid,
  output logic [7:0]  txData,
  input  logic        txReady,
  output logic [11:0] addr,
  output logic [31:0] wrData,
  output logic        wrEn,
  output logic        rdEn,
  input  logic [31:0] rdData,
  input  logic        rdValid,
  output logic        busy
);

  localparam int unsigned RW_W = $clog2(RD_WAIT_MAX + 1);

  if (TIMEOUT_CYCLES == 0 || RD_WAIT_MAX == 0) begin : g_param_check
    $error("uart_bus_master: TIMEOUT_CYCLES and RD_WAIT_MAX must be nonzero");
  end

  state_e          state_q, state_d;
  logic            op_wr_q, op_wr_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [11:0]     addr_q, addr_d;
  logic [31:0]     wr_data_q, wr_data_d;
  logic            wr_en_q, wr_en_d;
  logic            rd_en_q, rd_en_d;
  logic            busy_q, busy_d;
  logic [RW_W-1:0] rd_cnt_q, rd_cnt_d;
  logic            resp_load_c, resp_word_c, resp_done_c, timeout_c;
  logic [31:0]     resp_data_c;

`ifdef UART_BUS_MASTER_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] idle_q, idle_d;

  // Idle counter restarts on every received byte while a frame is being collected
  always_comb begin
    idle_d    = '0;
    timeout_c = 1'b0;
    if ((state_q == ADDR || state_q == DATA) && !rxValid) begin
      if (idle_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        timeout_c = 1'b1;
      end else begin
        idle_d = idle_q + TO_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) idle_q <= '0;
    else       idle_q <= idle_d;
  end
`else
  assign timeout_c = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    op_wr_d     = op_wr_q;
    byte_cnt_d  = byte_cnt_q;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
    rd_cnt_d    = rd_cnt_q;
    resp_load_c = 1'b0;
    resp_word_c = 1'b0;
    resp_data_c = {NAK_BYTE, 24'h0};
    unique case (state_q)
      IDLE: begin
        byte_cnt_d = 2'd0;
        if (rxValid) begin
          if (rxData == CMD_WR) begin
            state_d = ADDR;
            op_wr_d = 1'b1;
          end else if (rxData == CMD_RD) begin
            state_d = ADDR;
            op_wr_d = 1'b0;
          end else begin
            state_d     = RESP;
            resp_load_c = 1'b1;
          end
        end
      end
      ADDR: begin
        if (timeout_c) begin
          state_d     = RESP;
          resp_load_c = 1'b1;
        end else if (rxValid) begin
          if (byte_cnt_q == 2'd0) begin
            addr_d[11:8] = rxData[3:0];
            byte_cnt_d   = 2'd1;
          end else begin
            addr_d[7:0] = rxData;
            byte_cnt_d  = 2'd0;
            state_d     = op_wr_q ? DATA : READ;
          end
        end
      end
      DATA: begin
        if (timeout_c) begin
          state_d     = RESP;
          resp_load_c = 1'b1;
        end else if (rxValid) begin
          wr_data_d = {wr_data_q[23:0], rxData};
          if (byte_cnt_q == 2'd3) begin
            byte_cnt_d = 2'd0;
            state_d    = WRITE;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end
      WRITE: begin
        state_d     = RESP;
        resp_load_c = 1'b1;
        resp_data_c = {ACK_BYTE, 24'h0};
      end
      READ: begin
        state_d  = RWAIT;
        rd_cnt_d = '0;
      end
      RWAIT: begin
        if (rdValid) begin
          state_d     = RESP;
          resp_load_c = 1'b1;
          resp_word_c = 1'b1;
          resp_data_c = rdData;
        end else if (rd_cnt_q == RW_W'(RD_WAIT_MAX - 1)) begin
          state_d     = RESP;
          resp_load_c = 1'b1;
        end else begin
          rd_cnt_d = rd_cnt_q + RW_W'(1);
        end
      end
      RESP: begin
        if (resp_done_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes and busy follow the next state so they line up with the state register
  assign wr_en_d = (state_d == WRITE);
  assign rd_en_d = (state_d == READ);
  assign busy_d  = (state_d != IDLE);

  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      state_q    <= IDLE;
      op_wr_q    <= 1'b0;
      byte_cnt_q <= '0;
      addr_q     <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      rd_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_wr_q    <= op_wr_d;
      byte_cnt_q <= byte_cnt_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      busy_q     <= busy_d;
      rd_cnt_q   <= rd_cnt_d;
    end
  end

  uart_resp_ser u_resp_ser (
    .clk      (clk),
    .rst_n    (rstB),
    .load     (resp_load_c),
    .word     (resp_word_c),
    .data     (resp_data_c),
    .tx_ready (txReady),
    .tx_valid (txValid),
    .tx_data  (txData),
    .done_c   (resp_done_c)
  );

  assign addr   = addr_q;
  assign wrData = wr_data_q;
  assign wrEn   = wr_en_q;
  assign rdEn   = rd_en_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed scoreboard bench for uart_bus_master; the timeout case runs when UART_BUS_MASTER_TIMEOUT_EN is defined.
module tb_uart_bus_master;

  logic        clk = 1'b0;
  logic        rstB = 1'b0;
  logic        rxValid = 1'b0;
  logic [7:0]  rxData = '0;
  logic        txValid;
  logic [7:0]  txData;
  logic        txReady = 1'b0;
  logic [11:0] addr;
  logic [31:0] wrData;
  logic        wrEn;
  logic        rdEn;
  logic [31:0] rdData = '0;
  logic        rdValid = 1'b0;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int tx_seen = 0;
  logic [7:0] exp_q[$];

  uart_bus_master #(
    .TIMEOUT_CYCLES (100),
    .RD_WAIT_MAX    (16),
    .ACK_BYTE       (8'h06),
    .NAK_BYTE       (8'h15)
  ) dut (
    .clk     (clk),
    .rstB    (rstB),
    .rxValid (rxValid),
    .rxData  (rxData),
    .txValid (txValid),
    .txData  (txData),
    .txReady (txReady),
    .addr    (addr),
    .wrData  (wrData),
    .wrEn    (wrEn),
    .rdEn    (rdEn),
    .rdData  (rdData),
    .rdValid (rdValid),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Scoreboard: every accepted tx byte must match the next queued expectation
  always @(negedge clk) begin
    if (rstB && txValid && txReady) begin
      tx_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL tx_unexpected: observed byte %02h, expected no byte", txData);
      end else begin
        automatic logic [7:0] exp_b = exp_q.pop_front();
        assert (txData === exp_b) else begin
          errors++;
          $error("FAIL tx_byte: observed %02h expected %02h", txData, exp_b);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rstB) begin
      if (wrEn) wr_cnt++;
      if (rdEn) rd_cnt++;
      if (wrEn || rdEn) begin
        checks++;
        assert (!(wrEn && rdEn)) else begin
          errors++;
          $error("FAIL wr_rd_exclusive: observed wrEn=%0b rdEn=%0b expected not both", wrEn, rdEn);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rxValid = 1'b1;
    rxData  = b;
    tick();
    rxValid = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_tx_done(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || txValid || busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (n < 500) else begin
      errors++;
      $error("FAIL %s: observed %0d bytes still pending, expected 0", tag, exp_q.size());
    end
  endtask

  initial begin
    int n;
    int changes;
    int wr0;
    int seen0;
    logic [7:0] held;

    // Reset values
    repeat (3) tick();
    @(negedge clk);
    chk("rst_txValid", 32'(txValid), 32'h0);
    chk("rst_txData",  32'(txData),  32'h0);
    chk("rst_addr",    32'(addr),    32'h0);
    chk("rst_wrData",  wrData,       32'h0);
    chk("rst_wrEn",    32'(wrEn),    32'h0);
    chk("rst_rdEn",    32'(rdEn),    32'h0);
    chk("rst_busy",    32'(busy),    32'h0);
    tick();
    rstB = 1'b1;
    txReady = 1'b1;
    repeat (2) tick();

    // Write 57 04 02 DE AD BE EF
    exp_q.push_back(8'h06);
    send_byte(8'h57);
    @(negedge clk);
    chk("wr_busy", 32'(busy), 32'h1);
    send_byte(8'h04); send_byte(8'h02);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    @(negedge clk);
    chk("wr_en_latency", 32'(wrEn), 32'h1);
    chk("wr_addr", 32'(addr), 32'h402);
    chk("wr_data", wrData, 32'hDEADBEEF);
    tick();
    @(negedge clk);
    chk("wr_en_pulse", 32'(wrEn), 32'h0);
    chk("wr_tx_latency", 32'(txValid), 32'h1);
    wait_tx_done("wr_resp");
    chk("wr_count", 32'(wr_cnt), 32'd1);
    chk("wr_idle", 32'(busy), 32'h0);

    // Read 52 04 03, rdValid 3 cycles after rdEn
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h02);
    send_byte(8'h52); send_byte(8'h04); send_byte(8'h03);
    @(negedge clk);
    chk("rd_en_latency", 32'(rdEn), 32'h1);
    chk("rd_addr", 32'(addr), 32'h403);
    repeat (3) tick();
    rdValid = 1'b1;
    rdData  = 32'h00000002;
    tick();
    rdValid = 1'b0;
    rdData  = '0;
    wait_tx_done("rd_resp");
    chk("rd_count", 32'(rd_cnt), 32'd1);

    // Bad command
    exp_q.push_back(8'h15);
    send_byte(8'h41);
    wait_tx_done("bad_resp");
    chk("bad_no_wr", 32'(wr_cnt), 32'd1);
    chk("bad_no_rd", 32'(rd_cnt), 32'd1);
    chk("hold_addr", 32'(addr), 32'h403);
    chk("hold_wrData", wrData, 32'hDEADBEEF);

    // Read failure: no rdValid
    exp_q.push_back(8'h15);
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h10);
    @(negedge clk);
    chk("rdfail_en", 32'(rdEn), 32'h1);
    n = 0;
    while (!txValid && n < 100) begin
      tick();
      @(negedge clk);
      n++;
    end
    chk("rdfail_delay", 32'(n), 32'd17);
    wait_tx_done("rdfail_resp");
    chk("rdfail_idle", 32'(busy), 32'h0);

    // Backpressure on a read response; upper address nibble ignored
    txReady = 1'b0;
    seen0 = tx_seen;
    exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    exp_q.push_back(8'h56); exp_q.push_back(8'h78);
    send_byte(8'h52); send_byte(8'hF1); send_byte(8'h23);
    @(negedge clk);
    chk("bp_addr", 32'(addr), 32'h123);
    tick(); tick();
    rdValid = 1'b1;
    rdData  = 32'h12345678;
    tick();
    rdValid = 1'b0;
    rdData  = '0;
    n = 0;
    while (!txValid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_offer", 32'(txValid), 32'h1);
    held = txData;
    changes = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      rxValid = (i == 10);
      rxData  = 8'h57;
      @(negedge clk);
      if (txData !== held || txValid !== 1'b1) changes++;
    end
    rxValid = 1'b0;
    chk("bp_stable", 32'(changes), 32'd0);
    chk("bp_first_byte", 32'(held), 32'h12);
    @(posedge clk);
    #1;
    txReady = 1'b1;
    wait_tx_done("bp_resp");
    chk("bp_byte_count", 32'(tx_seen - seen0), 32'd4);
    chk("bp_rx_ignored", 32'(busy), 32'h0);

`ifdef UART_BUS_MASTER_TIMEOUT_EN
    // Inter-byte timeout
    wr0 = wr_cnt;
    exp_q.push_back(8'h15);
    send_byte(8'h57); send_byte(8'h04);
    n = 0;
    while (!txValid && n < 300) begin
      tick();
      @(negedge clk);
      n++;
    end
    chk("to_delay", 32'(n), 32'd100);
    wait_tx_done("to_resp");
    chk("to_no_wr", 32'(wr_cnt), 32'(wr0));
`endif

    // Reset mid-frame
    wr0 = wr_cnt;
    send_byte(8'h57); send_byte(8'h04); send_byte(8'h02); send_byte(8'hDE);
    rstB = 1'b0;
    #1;
    chk("mrst_addr",    32'(addr),    32'h0);
    chk("mrst_wrData",  wrData,       32'h0);
    chk("mrst_busy",    32'(busy),    32'h0);
    chk("mrst_txValid", 32'(txValid), 32'h0);
    chk("mrst_txData",  32'(txData),  32'h0);
    chk("mrst_wrEn",    32'(wrEn),    32'h0);
    chk("mrst_rdEn",    32'(rdEn),    32'h0);
    tick(); tick();
    rstB = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    chk("mrst_no_wr", 32'(wr_cnt), 32'(wr0));
    chk("mrst_idle", 32'(busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
